// File: rtl/mant_norm_ctrl.sv
// Normalization controller for the mantissa shift register: load, then shift until MSB=1.
// Optional MANT_NORM_STICKY_EN adds a sticky output capturing the bit lost on overflow shift.
module mant_norm_ctrl #(
    parameter int C_BIT_NUM = 24,
    parameter int C_ADJ_W   = $clog2(C_BIT_NUM) + 1
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 start,
    input  logic [C_BIT_NUM-1:0] mant_in,
    input  logic                 ovf_in,
    input  logic [C_BIT_NUM-1:0] sr_q,
    output logic                 sr_s0,
    output logic                 sr_s1,
    output logic [C_BIT_NUM-1:0] sr_d,
    output logic                 sr_sri,
    output logic                 sr_sli,
    output logic                 busy,
    output logic                 done,
    output logic [C_ADJ_W-1:0]   exp_adj,
    output logic                 zero
`ifdef MANT_NORM_STICKY_EN
   ,output logic                 sticky
`endif
);

    // state | meaning
    // IDLE  | waiting for start
    // LOAD  | parallel-load captured mantissa
    // SHR   | single right shift bringing the carry into the MSB
    // NORM  | left shift until MSB set or register found zero
    // DONE  | one-cycle result pulse
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHR, S_NORM, S_DONE} state_t;

    state_t                 state, state_nxt;
    logic                   ovf_r;
    logic                   accept;
    logic                   s0_nxt, s1_nxt, sri_nxt, done_nxt, busy_nxt, zero_nxt;
    logic [C_ADJ_W-1:0]     adj_nxt;
    logic [C_BIT_NUM-1:0]   q_pred;
    logic                   shift_pred;
`ifdef MANT_NORM_STICKY_EN
    logic                   sticky_nxt;
`endif

    assign accept = (state == S_IDLE) && start;
    assign sr_sli = 1'b0;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: state_nxt = ovf_r ? S_SHR : S_NORM;
            S_SHR:  state_nxt = S_DONE;
            S_NORM: if (sr_q == '0 || sr_q[C_BIT_NUM-1]) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Modes are registered, so the NORM shift decision is made one cycle early on the
    // predicted register contents: the loaded value after LOAD, the shifted value after NORM.
    always_comb begin
        q_pred     = (state == S_LOAD) ? sr_d : {sr_q[C_BIT_NUM-2:0], 1'b0};
        shift_pred = (q_pred != '0) && !q_pred[C_BIT_NUM-1];
        adj_nxt    = exp_adj;
        zero_nxt   = zero;
        busy_nxt   = busy;
`ifdef MANT_NORM_STICKY_EN
        sticky_nxt = sticky;
`endif
        case (state)
            S_IDLE: if (start) begin
                adj_nxt  = '0;
                zero_nxt = 1'b0;
                busy_nxt = 1'b1;
`ifdef MANT_NORM_STICKY_EN
                sticky_nxt = 1'b0;
`endif
            end
            S_SHR: begin
                adj_nxt = C_ADJ_W'(1);
`ifdef MANT_NORM_STICKY_EN
                sticky_nxt = sr_q[0];
`endif
            end
            S_NORM: begin
                if (sr_q == '0)                zero_nxt = 1'b1;
                else if (!sr_q[C_BIT_NUM-1])   adj_nxt  = exp_adj - C_ADJ_W'(1);
            end
            S_DONE: busy_nxt = 1'b0;
            default: ;
        endcase

        s0_nxt   = 1'b0;
        s1_nxt   = 1'b0;
        sri_nxt  = 1'b0;
        case (state_nxt)
            S_LOAD: begin s0_nxt = 1'b1; s1_nxt = 1'b1; end
            S_SHR:  begin s0_nxt = 1'b1; sri_nxt = 1'b1; end
            S_NORM: s1_nxt = shift_pred;
            default: ;
        endcase
        done_nxt = (state_nxt == S_DONE);
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            sr_s0   <= 1'b0;
            sr_s1   <= 1'b0;
            sr_sri  <= 1'b0;
            sr_d    <= '0;
            ovf_r   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            exp_adj <= '0;
            zero    <= 1'b0;
`ifdef MANT_NORM_STICKY_EN
            sticky  <= 1'b0;
`endif
        end else begin
            sr_s0   <= s0_nxt;
            sr_s1   <= s1_nxt;
            sr_sri  <= sri_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            exp_adj <= adj_nxt;
            zero    <= zero_nxt;
`ifdef MANT_NORM_STICKY_EN
            sticky  <= sticky_nxt;
`endif
            if (accept) begin
                sr_d  <= mant_in;
                ovf_r <= ovf_in;
            end
        end
    end

endmodule

// File: tb/tb_mant_norm_ctrl.sv
// Bench for mant_norm_ctrl: drives it against a universal shift register model and
// checks every operation against an arithmetic normalization reference.
module tb_mant_norm_ctrl;

    localparam int W = 24;
    localparam int A = $clog2(W) + 1;

    logic          CK = 1'b0;
    logic          RN, start, ovf_in;
    logic [W-1:0]  mant_in, sr_q, sr_d;
    logic          sr_s0, sr_s1, sr_sri, sr_sli, busy, done, zero;
    logic [A-1:0]  exp_adj;
`ifdef MANT_NORM_STICKY_EN
    logic          sticky;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CK = ~CK;

    mant_norm_ctrl dut (
        .CK(CK), .RN(RN), .start(start), .mant_in(mant_in), .ovf_in(ovf_in),
        .sr_q(sr_q), .sr_s0(sr_s0), .sr_s1(sr_s1), .sr_d(sr_d), .sr_sri(sr_sri),
        .sr_sli(sr_sli), .busy(busy), .done(done), .exp_adj(exp_adj), .zero(zero)
`ifdef MANT_NORM_STICKY_EN
       ,.sticky(sticky)
`endif
    );

    // downstream universal shift register, reset by the same RN
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) sr_q <= '0;
        else case ({sr_s0, sr_s1})
            2'b01: sr_q <= {sr_q[W-2:0], sr_sli};
            2'b10: sr_q <= {sr_sri, sr_q[W-1:1]};
            2'b11: sr_q <= sr_d;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] m, input logic o, input bit pulse);
        logic [W-1:0] q_e;
        logic [A-1:0] adj_e;
        logic         zero_e, stk_e;
        int           k, lat_e, shl_e, shr_e, cyc, shl, shr, busy_lo;
        // reference: normalize with plain arithmetic
        k = 0; stk_e = 1'b0; shr_e = 0;
        if (o) begin
            q_e = {1'b1, m[W-1:1]}; adj_e = A'(1); zero_e = 1'b0;
            stk_e = m[0]; shr_e = 1;
        end else if (m == 0) begin
            q_e = '0; adj_e = '0; zero_e = 1'b1;
        end else begin
            q_e = m;
            while (q_e < (1 << (W-1))) begin q_e = q_e * 2; k++; end
            adj_e = A'(0 - k); zero_e = 1'b0;
        end
        lat_e = 3 + k; shl_e = k;

        @(negedge CK);
        start = 1'b1; mant_in = m; ovf_in = o;
        @(posedge CK); #1;
        start = 1'b0; mant_in = W'($urandom); ovf_in = 1'($urandom);
        cyc = 1;
        check("load_mode", {sr_s0, sr_s1}, 2'b11);
        check("load_data", sr_d, m);
        check("start_clears", {exp_adj, zero}, '0);
        shl = 0; shr = 0; busy_lo = 0;
        while (!done && cyc < 64) begin
            @(posedge CK); #1;
            cyc++;
            start = pulse && (cyc == 2);
            if (start) mant_in = 24'h000001;
            if ({sr_s0, sr_s1} == 2'b01) shl++;
            if ({sr_s0, sr_s1} == 2'b10) shr++;
            if (!busy) busy_lo++;
        end
        start = 1'b0;
        check("done_seen", done, 1'b1);
        check("latency", cyc, lat_e);
        check("exp_adj", exp_adj, adj_e);
        check("zero", zero, zero_e);
        check("sr_q", sr_q, q_e);
        check("shl_cycles", shl, shl_e);
        check("shr_cycles", shr, shr_e);
        check("busy_held", busy_lo, 0);
`ifdef MANT_NORM_STICKY_EN
        check("sticky", sticky, stk_e);
`endif
        @(posedge CK); #1;
        check("done_pulse", done, 1'b0);
        check("busy_drop", busy, 1'b0);
        check("result_hold", {exp_adj, zero}, {adj_e, zero_e});
    endtask

    initial begin
        logic [W-1:0] m;
        int           kk;
        RN = 1'b0; start = 1'b0; mant_in = '0; ovf_in = 1'b0;
        repeat (2) @(posedge CK);
        #1;
        check("reset_outs", {sr_s0, sr_s1, sr_sri, sr_sli, busy, done, exp_adj, zero, sr_d}, '0);
        @(negedge CK) RN = 1'b1;

        // abort mid-NORM
        @(negedge CK); start = 1'b1; mant_in = 24'h000001; ovf_in = 1'b0;
        @(posedge CK); #1; start = 1'b0;
        repeat (4) @(posedge CK);
        #1;
        check("midnorm_busy", busy, 1'b1);
        #2 RN = 1'b0;
        #1;
        check("abort_outs", {sr_s0, sr_s1, sr_sri, sr_sli, busy, done, exp_adj, zero, sr_d}, '0);
        check("abort_sr_q", sr_q, '0);
        @(negedge CK) RN = 1'b1;

        run_op(24'h000000, 1'b0, 1'b0);
        run_op(24'h800000, 1'b0, 1'b0);
        run_op(24'h000001, 1'b0, 1'b0);
        run_op(24'h000003, 1'b1, 1'b0);
        run_op(24'h0F0000, 1'b0, 1'b1);
        run_op(24'h400001, 1'b0, 1'b0);
        run_op(24'h000000, 1'b1, 1'b0);
        run_op(24'hFFFFFE, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            kk = $urandom_range(0, W-1);
            m  = W'($urandom) >> kk;
            if ($urandom_range(0, 7) == 0) m = '0;
            run_op(m, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mant_norm_ctrl.md
Name: mant_norm_ctrl

Overview:
- Sequential normalization controller for the 24-bit mantissa path.
- Sits directly upstream of the universal shift register: drives its mode selects (S0/S1), parallel-load data and serial inputs, and observes its Q outputs.
- Loads a raw mantissa (plus carry-out) into the register, then shifts it until the MSB is 1.
- Reports the signed exponent adjustment and a zero flag to the exponent stage.

Parameters:
- C_BIT_NUM, 24, mantissa width; must match the shift register's width; minimum 4.
- C_ADJ_W, $clog2(C_BIT_NUM)+1, width of the signed exponent-adjust output.

Ports:
- CK  input  1  clock, rising edge
- RN  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- mant_in  input  C_BIT_NUM  raw mantissa; captured when start is accepted
- ovf_in  input  1  carry-out above mant_in MSB; captured with mant_in
- sr_q  input  C_BIT_NUM  Q of the downstream shift register
- sr_s0  output  1  shift register S0
- sr_s1  output  1  shift register S1
- sr_d  output  C_BIT_NUM  shift register parallel-load data
- sr_sri  output  1  serial-in at MSB during shift right
- sr_sli  output  1  serial-in at LSB during shift left; always 0
- busy  output  1  high from accepted start until DONE state is left
- done  output  1  one-cycle pulse; result valid
- exp_adj  output  C_ADJ_W  signed two's-complement exponent adjustment
- zero  output  1  mantissa was all zeros

Behaviour:
- Shift register mode encoding (S0,S1):
  - 00 hold
  - 01 shift left, Q[i] <= Q[i-1], LSB <= SLI
  - 10 shift right, Q[i] <= Q[i+1], MSB <= SRI
  - 11 parallel load
- Reset (RN=0, asynchronous): state=IDLE; sr_s0=sr_s1=0; sr_d=0; sr_sri=0; busy=0; done=0; exp_adj=0; zero=0.
- All outputs are registered or decoded purely from state; no combinational path from sr_q to outputs.
- FSM states: IDLE, LOAD, SHR, NORM, DONE.
- IDLE:
  - Modes 00.
  - On start=1: capture mant_in and ovf_in, clear exp_adj and zero, set busy, go to LOAD.
- LOAD:
  - Modes 11, sr_d = captured mantissa; register loads at the end of this cycle.
  - Next state is SHR if captured ovf=1, else NORM.
- SHR:
  - Modes 10, sr_sri=1 (carry enters MSB).
  - exp_adj <= +1; go to DONE.
- NORM (evaluates sr_q each cycle):
  - If sr_q==0: zero<=1, exp_adj unchanged (0), modes 00, go to DONE.
  - Else if sr_q[MSB]==1: modes 00, go to DONE.
  - Else: modes 01 (one left shift per cycle), exp_adj <= exp_adj-1, stay in NORM.
- DONE:
  - Modes 00, done=1 for exactly one cycle, then IDLE.
  - busy drops on entry to IDLE.
  - exp_adj and zero hold until the next accepted start.
- Latency, with start in cycle 0:
  - Already normalized, zero, or ovf: done in cycle 3.
  - k left shifts required: done in cycle 3+k.
  - Maximum k = C_BIT_NUM-1, giving exp_adj = -(C_BIT_NUM-1).
- Boundaries:
  - start while busy is ignored.
  - ovf=1 always takes exactly one right shift, regardless of mantissa value.
  - Reset mid-operation aborts immediately to IDLE with reset values; the shift register is reset by the same RN.
  - exp_adj never exceeds the +1 / -(C_BIT_NUM-1) range.

Optional Feature:
- Macro: MANT_NORM_STICKY_EN.
- Defined:
  - Extra output port sticky (1 bit), reset 0, cleared on accepted start.
  - In SHR, sticky <= sr_q[0] (the bit shifted out), used by downstream rounding.
- Undefined: port absent; no sticky logic.

Test Plan:
- Reset and zero case: RN low mid-NORM (mant_in=0x000001) -> all outputs 0, state IDLE. After release, start with mant_in=0x000000, ovf=0 -> done in cycle 3, zero=1, exp_adj=0.
- Already normalized: mant_in=0x800000, ovf=0 -> done in cycle 3, exp_adj=0, sr_q=0x800000, zero=0.
- Worst-case shift: mant_in=0x000001 -> 23 consecutive cycles of modes 01, done in cycle 26, exp_adj=-23 (0b101001), sr_q=0x800000.
- Overflow: mant_in=0x000003, ovf=1 -> one cycle of modes 10, done in cycle 3, exp_adj=+1, sr_q=0x800001; with MANT_NORM_STICKY_EN, sticky=1.
- Busy protection and reload: start with mant_in=0x0F0000 (4 shifts), pulse start again in cycle 2 with 0x000001 -> ignored; done in cycle 7, exp_adj=-4, sr_q=0xF00000. An immediately following start is accepted and clears the previous result.
